// File: rtl/agc_gain_sequencer_if.sv
// Control/status bundle between the packet front end and the AGC gain
// sequencer.
//
// master : the front end / host side; drives the packet events, the ADC
//          overload flag and the manual override, and observes the gain.
// slave  : the sequencer itself.
//
// Signals
//   start          packet-detect pulse, begins or restarts a search
//   overload       ADC saturation flag, sampled every cycle
//   payload_start  pulse, freezes the gain (ends a running search early)
//   packet_end     pulse, releases the lock and returns to idle
//   manual_en      host override enable (level)
//   manual_gain    host override gain value
//   gain_index     registered gain index to the VGA mapping function
//   busy           search in progress
//   locked         gain frozen
//   partial        lock came from an early-ended search (valid while locked)
interface agc_gain_sequencer_if #(
    parameter int GAIN_W = 6
);
    logic              start;
    logic              overload;
    logic              payload_start;
    logic              packet_end;
    logic              manual_en;
    logic [GAIN_W-1:0] manual_gain;
    logic [GAIN_W-1:0] gain_index;
    logic              busy;
    logic              locked;
    logic              partial;

    modport master (
        output start, overload, payload_start, packet_end, manual_en, manual_gain,
        input  gain_index, busy, locked, partial
    );

    modport slave (
        input  start, overload, payload_start, packet_end, manual_en, manual_gain,
        output gain_index, busy, locked, partial
    );
endinterface

// File: rtl/agc_gain_sequencer.sv
// Packet-level AGC gain sequencer.
//
// On a packet detect it runs a successive-approximation search over the gain
// index, MSB first. Each trial drives the candidate gain, waits SETTLE_CYC
// cycles for the analog chain to settle (overload ignored), then watches the
// ADC overload flag for DWELL_CYC cycles. A trial whose dwell saw no overload
// keeps its bit. After GAIN_W trials the gain is locked for the payload. A
// payload_start during the search locks early on the bits decided so far, and
// a host override bypasses the whole mechanism.
//
// Ports
//   clk    system clock
//   RESET  synchronous, active-high reset
//   bus    agc_gain_sequencer_if.slave (packet events, overload flag, manual
//          override in; gain_index, busy, locked, partial out)
module agc_gain_sequencer #(
    parameter int GAIN_W     = 6,
    parameter int SETTLE_CYC = 8,
    parameter int DWELL_CYC  = 16,
    parameter int IDLE_GAIN  = 63
) (
    input logic                 clk,
    input logic                 RESET,
    agc_gain_sequencer_if.slave bus
);

    localparam int MAX_CYC = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int PTR_W   = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;

    localparam logic [GAIN_W-1:0] IDLE_CODE   = GAIN_W'(IDLE_GAIN);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST  = CNT_W'(DWELL_CYC - 1);
    localparam logic [PTR_W-1:0]  PTR_TOP     = PTR_W'(GAIN_W - 1);
    localparam logic [GAIN_W-1:0] FIRST_TRIAL = GAIN_W'(1) << PTR_TOP;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DWELL,
        LOCK,
        MANUAL
    } state_t;

    state_t            state_q, state_d;
    logic [GAIN_W-1:0] code_q, code_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flag_q, flag_d;
    logic              busy_q, busy_d;
    logic              locked_q, locked_d;
    logic              partial_q, partial_d;

    logic              searching;
    logic              eff_flag;
    logic [GAIN_W-1:0] trial_bit;
    logic [GAIN_W-1:0] next_bit;
    logic [GAIN_W-1:0] code_dec;

    // The decision on the last dwell cycle must include that cycle's overload,
    // so it uses the sticky flag OR'd with the live input rather than the
    // registered flag alone.
    assign searching = (state_q == SETTLE) || (state_q == DWELL);
    assign eff_flag  = flag_q | bus.overload;
    assign trial_bit = GAIN_W'(1) << ptr_q;
    assign next_bit  = GAIN_W'(1) << (ptr_q - PTR_W'(1));
    assign code_dec  = eff_flag ? code_q : (code_q | trial_bit);

    // Next-state and next-output logic. The if/else chain encodes the event
    // priority: manual override, then leaving manual, then start, then
    // packet_end, then payload_start, and only then the normal search timing.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        gain_d    = gain_q;
        busy_d    = busy_q;
        locked_d  = locked_q;
        partial_d = partial_q;

        if (bus.manual_en) begin
            state_d   = MANUAL;
            gain_d    = bus.manual_gain;
            busy_d    = 1'b0;
            locked_d  = 1'b0;
            partial_d = 1'b0;
        end else if (state_q == MANUAL) begin
            // Start is deliberately not honoured on the cycle manual drops.
            state_d = IDLE;
            gain_d  = IDLE_CODE;
        end else if (bus.start) begin
            state_d   = SETTLE;
            code_d    = '0;
            ptr_d     = PTR_TOP;
            cnt_d     = '0;
            flag_d    = 1'b0;
            gain_d    = FIRST_TRIAL;
            busy_d    = 1'b1;
            locked_d  = 1'b0;
            partial_d = 1'b0;
        end else if (bus.packet_end && (state_q != IDLE)) begin
            state_d   = IDLE;
            gain_d    = IDLE_CODE;
            busy_d    = 1'b0;
            locked_d  = 1'b0;
            partial_d = 1'b0;
        end else if (bus.payload_start && searching) begin
            // Drop the bit under trial; only already-decided bits are safe.
            state_d   = LOCK;
            gain_d    = code_q;
            busy_d    = 1'b0;
            locked_d  = 1'b1;
            partial_d = 1'b1;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = DWELL;
                        cnt_d   = '0;
                        flag_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        code_d = code_dec;
                        cnt_d  = '0;
                        flag_d = 1'b0;
                        if (ptr_q != '0) begin
                            ptr_d   = ptr_q - PTR_W'(1);
                            gain_d  = code_dec | next_bit;
                            state_d = SETTLE;
                        end else begin
                            gain_d    = code_dec;
                            state_d   = LOCK;
                            busy_d    = 1'b0;
                            locked_d  = 1'b1;
                            partial_d = 1'b0;
                        end
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        flag_d = eff_flag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= IDLE;
            code_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            gain_q    <= IDLE_CODE;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            gain_q    <= gain_d;
            busy_q    <= busy_d;
            locked_q  <= locked_d;
            partial_q <= partial_d;
        end
    end

    assign bus.gain_index = gain_q;
    assign bus.busy       = busy_q;
    assign bus.locked     = locked_q;
    assign bus.partial    = partial_q;

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Self-checking bench for agc_gain_sequencer.
//
// A behavioural model tracks the sequencer in terms of elapsed cycles since
// the packet detect and which trials saw overload during their dwell window;
// the expected gain is derived arithmetically from that. Each driven cycle
// pushes the expected outputs into a scoreboard queue, and an independent
// monitor pops and compares them one cycle later.
module tb_agc_gain_sequencer;

    localparam int GAIN_W     = 6;
    localparam int SETTLE_CYC = 8;
    localparam int DWELL_CYC  = 16;
    localparam int IDLE_GAIN  = 63;
    localparam int TRIAL      = SETTLE_CYC + DWELL_CYC;
    localparam int LOCK_AT    = 1 + GAIN_W * TRIAL;

    logic clk = 1'b1;
    logic RESET;

    agc_gain_sequencer_if #(.GAIN_W(GAIN_W)) bus ();

    agc_gain_sequencer #(
        .GAIN_W    (GAIN_W),
        .SETTLE_CYC(SETTLE_CYC),
        .DWELL_CYC (DWELL_CYC),
        .IDLE_GAIN (IDLE_GAIN)
    ) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [GAIN_W-1:0] gain;
        logic              busy;
        logic              locked;
        logic              partial;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle_no    = 0;

    // Reference model state.
    typedef enum int {M_IDLE, M_SEARCH, M_LOCK, M_MANUAL} mmode_t;
    mmode_t m_mode    = M_IDLE;
    int     m_elapsed = 0;
    bit     m_hit[GAIN_W];
    int     m_gain    = IDLE_GAIN;
    bit     m_partial = 1'b0;

    // Plant: 0 overload at gain >= threshold, 1 always, 2 never,
    // 3 random pulses confined to settle windows.
    int plant_kind = 0;
    int plant_thr  = 40;

    // Gain made of the first 'trials' decided bits.
    function automatic int decided_code(int trials);
        int c;
        c = 0;
        for (int i = 0; i < trials; i++)
            if (!m_hit[i]) c += 1 << (GAIN_W - 1 - i);
        return c;
    endfunction

    function automatic int model_gain();
        int t;
        if (m_mode == M_SEARCH) begin
            t = (m_elapsed - 1) / TRIAL;
            return decided_code(t) + (1 << (GAIN_W - 1 - t));
        end
        return m_gain;
    endfunction

    function automatic bit plant_overload();
        case (plant_kind)
            0: return model_gain() >= plant_thr;
            1: return 1'b1;
            2: return 1'b0;
            default: begin
                if (m_mode == M_SEARCH && ((m_elapsed - 1) % TRIAL) < SETTLE_CYC)
                    return bit'($urandom_range(0, 1));
                return 1'b0;
            end
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit pe, input bit ps,
                              input bit me, input int mg, input bit ovl);
        int t;
        int ph;
        if (rst) begin
            m_mode = M_IDLE; m_gain = IDLE_GAIN; m_partial = 1'b0;
        end else if (me) begin
            m_mode = M_MANUAL; m_gain = mg; m_partial = 1'b0;
        end else if (m_mode == M_MANUAL) begin
            m_mode = M_IDLE; m_gain = IDLE_GAIN;
        end else if (st) begin
            m_mode = M_SEARCH; m_elapsed = 1; m_partial = 1'b0;
            for (int i = 0; i < GAIN_W; i++) m_hit[i] = 1'b0;
        end else if (pe && m_mode != M_IDLE) begin
            m_mode = M_IDLE; m_gain = IDLE_GAIN; m_partial = 1'b0;
        end else if (ps && m_mode == M_SEARCH) begin
            m_gain = decided_code((m_elapsed - 1) / TRIAL);
            m_mode = M_LOCK; m_partial = 1'b1;
        end else if (m_mode == M_SEARCH) begin
            t  = (m_elapsed - 1) / TRIAL;
            ph = (m_elapsed - 1) % TRIAL;
            if (ph >= SETTLE_CYC && ovl) m_hit[t] = 1'b1;
            m_elapsed++;
            if (m_elapsed == LOCK_AT) begin
                m_mode = M_LOCK; m_gain = decided_code(GAIN_W); m_partial = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic applyStimulus(input bit rst, input bit st, input bit pe, input bit ps,
                                 input bit me, input int mg);
        bit   ovl;
        exp_t e;
        @(negedge clk);
        ovl               = plant_overload();
        RESET             = rst;
        bus.start         = st;
        bus.packet_end    = pe;
        bus.payload_start = ps;
        bus.manual_en     = me;
        bus.manual_gain   = mg[GAIN_W-1:0];
        bus.overload      = ovl;
        model_step(rst, st, pe, ps, me, mg & ((1 << GAIN_W) - 1), ovl);
        e.gain    = GAIN_W'(model_gain());
        e.busy    = (m_mode == M_SEARCH);
        e.locked  = (m_mode == M_LOCK);
        e.partial = (m_mode == M_LOCK) && m_partial;
        sb.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (bus.gain_index !== e.gain || bus.busy !== e.busy ||
            bus.locked !== e.locked || bus.partial !== e.partial) begin
            miscompares++;
            $display("[TB] FAIL outputs cycle %0d: got gain=%0d busy=%b locked=%b partial=%b, expected gain=%0d busy=%b locked=%b partial=%b",
                     cycle_no, bus.gain_index, bus.busy, bus.locked, bus.partial,
                     e.gain, e.busy, e.locked, e.partial);
        end
    endtask

    // Monitor: compares whatever the DUT presents after each edge.
    always @(posedge clk) begin
        #1;
        cycle_no++;
        if (sb.size() != 0) checkOutput(sb.pop_front());
    end

    initial begin
        bit me;
        int r;
        int len;

        RESET = 1'b1;
        bus.start = 1'b0; bus.packet_end = 1'b0; bus.payload_start = 1'b0;
        bus.manual_en = 1'b0; bus.manual_gain = '0; bus.overload = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(2);

        // Threshold plant at 40: trials 32,48,40,36,38,39, lock on 39.
        plant_kind = 0; plant_thr = 40;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(150);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Saturated, silent and settle-only-overload plants.
        for (int k = 1; k <= 3; k++) begin
            plant_kind = k;
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            idle_cycles(150);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        end

        // Early lock during trial 48, then release.
        plant_kind = 0; plant_thr = 40;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(29);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        idle_cycles(5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle_cycles(3);

        // Restart mid-search, then start+packet_end together from LOCK.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(59);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(150);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle_cycles(150);

        // Manual override mid-dwell; start ignored while manual.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        idle_cycles(3);

        // Reset mid-search and while locked, with start/overload in the reset cycle.
        plant_kind = 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(50);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(150);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(3);

        // Randomized episodes with sprinkled events.
        me = 1'b0;
        for (int ep = 0; ep < 40; ep++) begin
            plant_kind = $urandom_range(0, 3);
            plant_thr  = $urandom_range(0, 64);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            len = $urandom_range(20, 170);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 999);
                if (r < 3) me = !me;
                applyStimulus(r == 999, (r >= 3 && r < 7), (r >= 7 && r < 11),
                              (r >= 11 && r < 19), me, $urandom_range(0, 63));
            end
            me = 1'b0;
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
